// File: rtl/octspi_target_mem_if.sv
// Octal-SPI pad-side bus between a host (master) and the target core (slave).
// The pad IOBUF lives outside the core, so data in, data out and the enables are separate signals.
interface octspi_target_mem_if;
  logic       ncs;
  logic [7:0] dq_i;
  logic [7:0] dq_o;
  logic       dq_oe;
  logic       dqs_o;
  logic       dqs_oe;

  modport master (
    output ncs,
    output dq_i,
    input  dq_o,
    input  dq_oe,
    input  dqs_o,
    input  dqs_oe
  );

  modport slave (
    input  ncs,
    input  dq_i,
    output dq_o,
    output dq_oe,
    output dqs_o,
    output dqs_oe
  );
endinterface

// File: rtl/octspi_target_mem.sv
// Octal-SPI SDR target with on-chip byte RAM.
// An 8-byte big-endian header carries {op, size}, len[23:0] and addr[31:0].
// Writes stream into the RAM. Reads and status reads wait DMY_CYC dummy cycles.
// The last dummy cycle is a DQS preamble, and data follows with DQS held high.
// Addresses wrap modulo the RAM depth. Status flags are sticky.
// ADDR_W must be below 32.
module octspi_target_mem #(
  parameter int          ADDR_W   = 18,
  parameter int          DMY_CYC  = 2,
  parameter logic [3:0]  OP_WRITE = 4'hA,
  parameter logic [3:0]  OP_READ  = 4'h2,
  parameter logic [3:0]  OP_STAT  = 4'h5
) (
  input  logic                  clkin,
  input  logic                  reset_n,
  octspi_target_mem_if.slave    bus,
  output logic                  busy,
  output logic [7:0]            status
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [23:0]       DMY_LAST = 24'(DMY_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WDATA,
    S_DUMMY,
    S_RDATA,
    S_SDATA,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [23:0]       cnt_q, cnt_d;       // header, dummy and data cycle counter
  logic [55:0]       hdr_q, hdr_d;       // first seven header bytes, shifted in MSB first
  logic [3:0]        op_q, op_d;
  logic [23:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        status_q, status_d; // [0] bad op, [1] overrun, [2] underrun, [3] write done
  logic              wr_en;

  logic [7:0]        ram [DEPTH];
  logic [7:0]        rd_q;

  // The header is decoded while its eighth byte is still on the pads.
  logic [63:0]       hdr_full;
  logic [3:0]        hdr_op;
  logic [23:0]       hdr_len;
  logic [ADDR_W-1:0] hdr_addr;
  logic [23:0]       cnt_inc;
  logic              unused_hdr;

  assign hdr_full   = {hdr_q, bus.dq_i};
  assign hdr_op     = hdr_full[63:60];
  assign hdr_len    = hdr_full[55:32];
  assign hdr_addr   = hdr_full[ADDR_W-1:0];
  assign cnt_inc    = cnt_q + 24'd1;
  // The size nibble and the address bits above the RAM width are accepted but ignored.
  assign unused_hdr = ^{hdr_full[59:56], hdr_full[31:ADDR_W]};

  // Next-state logic: protocol sequencing and sticky flag updates.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    op_d     = op_q;
    len_d    = len_q;
    addr_d   = addr_q;
    status_d = status_q;
    wr_en    = 1'b0;

    if (bus.ncs) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      // Data states are left automatically when the count reaches len, so being here means it is short.
      if (state_q == S_WDATA || state_q == S_RDATA) status_d[2] = 1'b1;
      // Ending a status read acknowledges the error flags. Write-done stays set.
      if (state_q == S_SDATA) status_d[2:0] = 3'b000;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
        S_HDR: begin
          hdr_d = hdr_full[55:0];
          cnt_d = cnt_inc;
          if (cnt_q == 24'd7) begin
            cnt_d  = '0;
            op_d   = hdr_op;
            len_d  = hdr_len;
            addr_d = hdr_addr;
            if (hdr_op == OP_WRITE) begin
              state_d = (hdr_len == 24'd0) ? S_DONE : S_WDATA;
            end else if (hdr_op == OP_READ || hdr_op == OP_STAT) begin
              state_d = S_DUMMY;
            end else begin
              state_d     = S_DONE;
              status_d[0] = 1'b1;
            end
          end
        end
        S_WDATA: begin
          wr_en  = 1'b1;
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d     = S_DONE;
            status_d[3] = 1'b1;
          end
        end
        S_DUMMY: begin
          cnt_d = cnt_inc;
          if (cnt_q == DMY_LAST) begin
            cnt_d = '0;
            if (op_q == OP_STAT) begin
              state_d = S_SDATA;
            end else if (len_q == 24'd0) begin
              state_d = S_DONE;
            end else begin
              // Byte 0 is already being fetched, so the address moves ahead to byte 1.
              state_d = S_RDATA;
              addr_d  = addr_q + ADDR_ONE;
            end
          end
        end
        S_RDATA: begin
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) state_d = S_DONE;
        end
        S_SDATA: begin
          state_d = S_SDATA;
        end
        S_DONE: begin
          status_d[1] = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and control registers, asynchronously cleared.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hdr_q    <= '0;
      op_q     <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      status_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so each register samples the values from before this edge.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      op_q     <= op_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      status_q <= status_d;
    end
  end

  // Byte RAM with a write port and a registered read of the current address.
  always_ff @(posedge clkin) begin
    // NOTE: the RAM and its read register are deliberately not reset. Contents survive reset, and the array maps onto block RAM.
    if (wr_en) ram[addr_q] <= bus.dq_i;
    rd_q <= ram[addr_q];
  end

  // Pad outputs are decoded from state. Enables release as soon as ncs rises.
  always_comb begin
    logic preamble;
    logic drive;
    preamble   = (state_q == S_DUMMY) && (cnt_q == DMY_LAST);
    drive      = preamble || (state_q == S_RDATA) || (state_q == S_SDATA);
    bus.dq_oe  = drive && !bus.ncs;
    bus.dqs_oe = drive && !bus.ncs;
    bus.dqs_o  = (state_q == S_RDATA) || (state_q == S_SDATA);
    bus.dq_o   = 8'h00;
    if (state_q == S_RDATA)      bus.dq_o = rd_q;
    else if (state_q == S_SDATA) bus.dq_o = {4'h0, status_q};
  end

  assign busy   = (state_q != S_IDLE);
  assign status = {4'h0, status_q};

endmodule

// File: tb/tb_octspi_target_mem.sv
// Bench for octspi_target_mem. The host drives on falling edges.
// A scoreboard monitor checks every byte the target drives.
// A second instance with DMY_CYC=5 shares the bus stimulus and is used to compare read latency.
module tb_octspi_target_mem;

  logic       clkin = 1'b0;
  logic       reset_n;
  logic       ncs;
  logic [7:0] dq;
  logic       busy0, busy1;
  logic [7:0] status0, status1;

  always #5 clkin = ~clkin;

  octspi_target_mem_if bus0();
  octspi_target_mem_if bus1();

  assign bus0.ncs  = ncs;
  assign bus0.dq_i = dq;
  assign bus1.ncs  = ncs;
  assign bus1.dq_i = dq;

  octspi_target_mem #(.DMY_CYC(2)) dut0 (
    .clkin   (clkin),
    .reset_n (reset_n),
    .bus     (bus0.slave),
    .busy    (busy0),
    .status  (status0)
  );

  octspi_target_mem #(.DMY_CYC(5)) dut1 (
    .clkin   (clkin),
    .reset_n (reset_n),
    .bus     (bus1.slave),
    .busy    (busy1),
    .status  (status1)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         t0     = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_e;

  logic       lat_arm = 1'b0;
  logic       seen0, seen1;
  int         lat0, lat1;
  logic [7:0] d1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clkin) cyc <= cyc + 1;

  // Scoreboard monitor. A preamble cycle must drive zero, and every strobed byte must match the next expected one.
  always begin
    @(posedge clkin);
    #1;
    if (bus0.dq_oe) begin
      if (bus0.dqs_o) begin
        if (exp_q.size() == 0) begin
          check("dq_unexpected", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("dq_data", {24'h0, bus0.dq_o}, {24'h0, mon_e});
        end
      end else begin
        check("dq_preamble", {24'h0, bus0.dq_o}, 32'h0);
      end
    end
  end

  // Latency probe: records the first strobed data cycle of each instance, counted from the first header edge.
  always begin
    @(posedge clkin);
    #1;
    if (lat_arm) begin
      if (!seen0 && bus0.dq_oe && bus0.dqs_o) begin
        lat0  = cyc - t0;
        seen0 = 1'b1;
      end
      if (!seen1 && bus1.dq_oe && bus1.dqs_o) begin
        lat1  = cyc - t0;
        d1    = bus1.dq_o;
        seen1 = 1'b1;
      end
    end
  end

  task automatic frame_hdr(input logic [3:0] op, input logic [23:0] len, input logic [31:0] addr);
    logic [63:0] h;
    h = {op, 4'h0, len, addr};
    @(negedge clkin);
    ncs = 1'b0;
    dq  = 8'h00;
    t0  = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkin);
      dq = h[63-8*i -: 8];
    end
  endtask

  task automatic frame_end();
    @(negedge clkin);
    ncs = 1'b1;
    dq  = 8'h00;
    @(negedge clkin);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [23:0] len, input int n,
                          input logic [63:0] d);
    frame_hdr(4'hA, len, addr);
    for (int i = 0; i < n; i++) begin
      @(negedge clkin);
      dq = d[63-8*i -: 8];
    end
    frame_end();
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [63:0] d,
                         input int hold);
    for (int i = 0; i < len; i++) exp_q.push_back(d[63-8*i -: 8]);
    frame_hdr(4'h2, 24'(len), addr);
    repeat (hold) begin
      @(negedge clkin);
      dq = 8'h00;
    end
    frame_end();
    check("rd_drain", exp_q.size(), 0);
  endtask

  task automatic do_stat(input logic [7:0] exp, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp);
    frame_hdr(4'h5, 24'h0, 32'h0);
    repeat (2 + n - 1) @(negedge clkin);
    frame_end();
    check("stat_drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    ncs     = 1'b1;
    dq      = 8'h00;
    seen0   = 1'b0;
    seen1   = 1'b0;
    lat0    = -1;
    lat1    = -1;
    d1      = 8'h00;
    repeat (3) @(negedge clkin);
    check("rst_busy",   {31'h0, busy0},       32'h0);
    check("rst_status", {24'h0, status0},     32'h0);
    check("rst_dq_oe",  {31'h0, bus0.dq_oe},  32'h0);
    check("rst_dqs_oe", {31'h0, bus0.dqs_oe}, 32'h0);
    check("rst_dq_o",   {24'h0, bus0.dq_o},   32'h0);
    check("rst_dqs_o",  {31'h0, bus0.dqs_o},  32'h0);
    reset_n = 1'b1;
    @(negedge clkin);

    // Basic write and read-back.
    do_write(32'h10, 24'd4, 4, 64'h11223344_00000000);
    check("wr_done_status", {24'h0, status0}, 32'h08);
    do_read(32'h10, 4, 64'h11223344_00000000, 6);

    // Address wrap at the top of the RAM.
    do_write(32'h3FFFF, 24'd3, 3, 64'hAABBCC00_00000000);
    do_read(32'h3FFFF, 3, 64'hAABBCC00_00000000, 5);
    do_read(32'h0, 2, 64'hBBCC0000_00000000, 4);

    // Bad opcode, then two status reads.
    frame_hdr(4'h7, 24'h0, 32'h0);
    frame_end();
    check("badop_status", {24'h0, status0}, 32'h09);
    do_stat(8'h09, 2);
    do_stat(8'h08, 2);
    check("stat_cleared", {24'h0, status0}, 32'h08);

    // Overrun: len=2 with four data cycles stores only two bytes.
    do_write(32'h100, 24'd4, 4, 64'hF0F1F2F3_00000000);
    do_write(32'h100, 24'd2, 4, 64'h55667788_00000000);
    check("overrun_status", {24'h0, status0}, 32'h0A);
    do_read(32'h100, 4, 64'h5566F2F3_00000000, 6);

    // Underrun: len=5 with ncs released after three bytes.
    frame_hdr(4'hA, 24'd5, 32'h200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clkin);
      dq = 8'hC0 + 8'(i);
    end
    @(negedge clkin);
    ncs = 1'b1;
    check("under_busy_mid", {31'h0, busy0},      32'h1);
    check("under_no_drive", {31'h0, bus0.dq_oe}, 32'h0);
    @(posedge clkin);
    #1;
    check("under_busy_after", {31'h0, busy0},   32'h0);
    check("under_status",     {24'h0, status0}, 32'h0E);
    @(negedge clkin);

    // Asynchronous reset in the middle of a read.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    frame_hdr(4'h2, 24'd4, 32'h10);
    repeat (3) @(negedge clkin);
    @(posedge clkin);
    #2;
    check("midrd_oe_before", {31'h0, bus0.dq_oe}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrd_dq_oe",  {31'h0, bus0.dq_oe},  32'h0);
    check("midrd_dqs_oe", {31'h0, bus0.dqs_oe}, 32'h0);
    check("midrd_busy",   {31'h0, busy0},       32'h0);
    check("midrd_status", {24'h0, status0},     32'h0);
    @(negedge clkin);
    ncs     = 1'b1;
    reset_n = 1'b1;
    @(negedge clkin);
    check("midrd_drain", exp_q.size(), 0);
    do_read(32'h10, 4, 64'h11223344_00000000, 6);

    // Read latency for DMY_CYC=2 (dut0) and DMY_CYC=5 (dut1).
    seen0   = 1'b0;
    seen1   = 1'b0;
    lat0    = -1;
    lat1    = -1;
    lat_arm = 1'b1;
    exp_q.push_back(8'h11);
    frame_hdr(4'h2, 24'd1, 32'h10);
    repeat (7) @(negedge clkin);
    frame_end();
    lat_arm = 1'b0;
    check("lat_dmy2",  lat0, 32'd10);
    check("lat_dmy5",  lat1, 32'd13);
    check("dmy5_data", {24'h0, d1}, 32'h11);
    check("lat_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/octspi_target_mem.md
Name: octspi_target_mem

Overview:
Parametrised octal-SPI (SDR) target core with on-chip byte RAM, and the next generation of the board's OSPI slave endpoint. It decodes an 8-byte header (opcode, 24-bit length, 32-bit address), inserts programmable dummy cycles before reads, and streams write or read data with wrapping addresses. It adds DQS preamble/strobe, a status opcode, and sticky error flags. Pad IOBUFs live in the top level; this core exposes split i/o/oe pins.

Parameters:
ADDR_W, 18, RAM address width; depth = 2^ADDR_W bytes (262144 = 512*512)
DMY_CYC, 2, dummy cycles before read/status data; legal range 2..15
OP_WRITE, 4'hA, write opcode
OP_READ, 4'h2, read opcode
OP_STAT, 4'h5, status-read opcode

Ports:
clkin  in  1  bus clock; all sampling and launching on rising edge
reset_n  in  1  asynchronous active-low reset
ncs  in  1  chip select, active low
dq_i  in  8  data from pads
dq_o  out  8  data to pads
dq_oe  out  1  data output enable (1 = drive)
dqs_o  out  1  data strobe to pad
dqs_oe  out  1  strobe output enable
busy  out  1  high while a transaction is in progress (state != IDLE)
status  out  8  sticky status register, mirrored live

Behaviour:
- Reset (reset_n low, async): state IDLE; counters 0; dq_o=0, dq_oe=0, dqs_o=0, dqs_oe=0, busy=0, status=0. RAM contents undefined.
- ncs high at any edge: state returns to IDLE, counters clear. dq_oe/dqs_oe are gated combinationally by ~ncs, so pads release without waiting for a clock.
- States: IDLE -> HDR on the first edge with ncs low; HDR runs 8 cycles.
- HDR bytes, big-endian: byte0 = {op[3:0], size[3:0]} (size stored, unused); bytes1-3 = len[23:0]; bytes4-7 = addr[31:0]. Only addr[ADDR_W-1:0] is used.
- After header byte7:
  - OP_WRITE, len>0 -> WDATA.
  - OP_READ or OP_STAT -> DUMMY (DMY_CYC cycles).
  - Write with len=0 -> DONE.
  - Any other opcode -> DONE, status[0] set.
- WDATA: each cycle ram[addr] <= dq_i, addr += 1 modulo 2^ADDR_W, data_cnt += 1. When data_cnt reaches len -> DONE, status[3] set.
- DUMMY:
  - RAM prefetch of addr starts at the first dummy cycle.
  - Last dummy cycle is the preamble: dq_oe=1, dqs_oe=1, dq_o=8'h00, dqs_o=0.
  - Then READ goes to RDATA (len>0) or DONE (len=0); STAT goes to SDATA.
- RDATA:
  - Byte k = ram[addr0+k mod depth] is launched on the edge that starts data cycle k; dqs_o=1 in every data cycle.
  - Read latency is fixed: first data byte launches DMY_CYC+8 edges after the first header edge.
  - When data_cnt reaches len -> DONE.
- SDATA: dq_o = status every cycle until ncs rises. The rising ncs that ends a status read clears status[2:0]; bit 3 clears only on reset.
- DONE: outputs released (dq_oe=0, dqs_oe=0).
  - Any further ncs-low cycle sets status[1] (overrun). Extra write bytes are not stored; extra read cycles drive nothing.
- Underrun: ncs rises in WDATA/RDATA before data_cnt==len -> status[2] set. Bytes already written stay written.
- Length compare uses full 24-bit counters; len up to 2^24-1 is legal. Address wrap is silent.
- Status bits: [0] bad opcode, [1] overrun, [2] underrun, [3] write completed, [7:4] = 0.
- Async reset mid-transaction: immediate IDLE, all outputs to reset values; RAM unaffected.

Test Plan:
- Write 4 bytes: header A0 000004 00000010, data 11 22 33 44, then read 4 bytes from 0x10 -> after 2 dummy cycles (preamble 00, dqs 0) dq_o = 11,22,33,44 with dqs_o=1 each cycle; status[3]=1.
- Wrap: write 3 bytes at addr 0x3FFFF (ADDR_W=18), data AA BB CC -> ram[3FFFF]=AA, ram[0]=BB, ram[1]=CC; a read of 3 bytes from 0x3FFFF returns the same.
- Bad opcode 0x7, then status read (header 50 000000 00000000) -> dq_o = 0x09 (bits 0 and 3 set from prior write); after ncs rises a second status read returns 0x08.
- Overrun/underrun: write len=2 with ncs held 4 data cycles -> only 2 bytes stored, status[1]=1. Write len=5 with ncs released after 3 bytes -> status[2]=1, busy=0 on the next edge.
- Async reset asserted mid-read with dq_oe=1 -> dq_oe, dqs_oe and busy drop immediately; a subsequent read of previously written data is still correct.
- Sweep DMY_CYC=2,5 -> first read byte launches exactly 10 and 13 edges respectively after the first header edge.
